// File: rtl/array_writer_if.sv
// Load/read bus for array_writer.
// master drives requests and samples; slave owns the table.
interface array_writer_if #(
    parameter int ADDR_BITS = 2,
    parameter int WIDTH     = 25
);
    logic                    start;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    loaded;
    logic                    busy;
    logic [ADDR_BITS-1:0]    rd_addr;
    logic signed [WIDTH-1:0] rd_data;

    modport master (
        output start,
        output in_data,
        output in_valid,
        output rd_addr,
        input  in_ready,
        input  loaded,
        input  busy,
        input  rd_data
    );

    modport slave (
        input  start,
        input  in_data,
        input  in_valid,
        input  rd_addr,
        output in_ready,
        output loaded,
        output busy,
        output rd_data
    );
endinterface

// File: rtl/array_writer.sv
// Sequential table loader: streams 2**ADDR_BITS fixed-point samples
// into a register table and serves registered reads from it.
module array_writer #(
    parameter int ADDR_BITS = 2,
    parameter int WIDTH     = 25,
    parameter int EXPONENT  = -16
) (
    input logic         clk,
    input logic         rst,
    array_writer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST = '1;

    // Words are stored raw; the binary point only matters to consumers.
    if (EXPONENT > 0) begin : g_integer_scale
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t                  state_q;
    logic [ADDR_BITS-1:0]    wr_ptr_q;
    logic [ADDR_BITS-1:0]    wr_ptr_d;
    logic signed [WIDTH-1:0] tbl_q [DEPTH];
    logic signed [WIDTH-1:0] rd_data_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    loaded_q;
    logic                    xfer;

    assign xfer     = bus.in_valid && in_ready_q;
    assign wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);

    // Control FSM; handshake and status outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q    <= LOAD;
                        wr_ptr_q   <= '0;
                        loaded_q   <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_ptr_q <= wr_ptr_d;
                        if (wr_ptr_q == LAST) begin
                            state_q    <= DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            loaded_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Table storage: one entry written per accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (xfer) begin
            tbl_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Registered read port; a same-edge write returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= tbl_q[bus.rd_addr];
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.loaded   = loaded_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_array_writer.sv
// Self-checking bench for array_writer against a behavioural
// table model (array + load cursor) with directed and random steps.
module tb_array_writer;
    localparam int AB = 2;
    localparam int W  = 25;
    localparam int N  = 2 ** AB;

    typedef logic signed [W-1:0] vec_t [N];

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    array_writer_if #(.ADDR_BITS(AB), .WIDTH(W)) bus ();

    array_writer #(
        .ADDR_BITS(AB),
        .WIDTH    (W),
        .EXPONENT (-16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [W-1:0] m_tbl [N];
    bit                  m_load;
    bit                  m_done;
    int                  m_ptr;
    logic signed [W-1:0] m_rd;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, m_load});
        chk({tag, ".busy"}, {31'b0, bus.busy}, {31'b0, m_load});
        chk({tag, ".loaded"}, {31'b0, bus.loaded}, {31'b0, m_done});
        chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_rd));
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_tbl[i] = '0;
        m_load = 1'b0;
        m_done = 1'b0;
        m_ptr  = 0;
        m_rd   = '0;
    endtask

    // Advance the model on current inputs, take one edge, then compare.
    task automatic tick(input string tag);
        logic signed [W-1:0] nrd;
        nrd = m_tbl[bus.rd_addr];
        if (m_load) begin
            if (bus.in_valid) begin
                m_tbl[m_ptr] = bus.in_data;
                m_ptr++;
                if (m_ptr == N) begin
                    m_ptr  = 0;
                    m_load = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (bus.start) begin
            m_load = 1'b1;
            m_ptr  = 0;
            m_done = 1'b0;
        end
        m_rd = nrd;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input vec_t v, input int stall_at,
                        input int stall_len, input int start_at);
        int bc;
        bc = 0;
        bus.start = 1'b1;
        tick("ld.start");
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = W'($urandom);
                    if (bus.busy === 1'b1) bc++;
                    tick("ld.stall");
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
            bus.start    = (i == start_at);
            if (bus.busy === 1'b1) bc++;
            tick("ld.xfer");
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (bus.busy === 1'b1) bc++;
        chk("ld.busy_cycles", 32'(bc), 32'(N + stall_len));
        chk("ld.loaded", {31'b0, bus.loaded}, 32'd1);
    endtask

    task automatic readback(input vec_t v, input string tag);
        for (int a = 0; a < N; a++) begin
            bus.rd_addr = AB'(a);
            tick(tag);
            chk({tag, ".word"}, 32'(bus.rd_data), 32'(v[a]));
        end
    endtask

    initial begin
        vec_t v1;
        vec_t v2;
        vec_t z;
        v1[0] = 25'sd655360;
        v1[1] = -25'sd163840;
        v1[2] = 25'sd0;
        v1[3] = 25'sd81920;
        for (int i = 0; i < N; i++) begin
            v2[i] = W'($urandom);
            z[i]  = '0;
        end

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_addr  = '0;
        rst          = 1'b1;
        model_reset();
        #3;
        check_all("rst.async");
        @(posedge clk);
        #1;
        check_all("rst.hold");
        rst = 1'b0;

        readback(z, "sweep0");

        load(v1, -1, 0, -1);
        readback(v1, "rb.basic");

        load(v1, 2, 3, -1);
        readback(v1, "rb.stall");

        load(v2, -1, 0, 2);
        readback(v2, "rb.restart");

        // Async reset partway through a load, between edges.
        bus.start = 1'b1;
        tick("ar.start");
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            tick("ar.xfer");
        end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("ar.async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            tick("ar.ignored");
        end
        bus.in_valid = 1'b0;
        readback(z, "ar.zero");

        // Same-edge read of the entry being written returns old data.
        bus.rd_addr = AB'(1);
        bus.start   = 1'b1;
        tick("rw.start");
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom);
        tick("rw.x0");
        bus.in_data = 25'sd655360;
        tick("rw.x1");
        chk("rw.old", 32'(bus.rd_data), 32'd0);
        bus.in_data = W'($urandom);
        tick("rw.x2");
        chk("rw.new", 32'(bus.rd_data), 32'd655360);
        bus.in_data = W'($urandom);
        tick("rw.x3");
        bus.in_valid = 1'b0;
        tick("rw.idle");

        for (int c = 0; c < 400; c++) begin
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.in_valid = $urandom_range(0, 1) == 1;
            bus.in_data  = W'($urandom);
            bus.rd_addr  = AB'($urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/array_writer.md
ARRAY_WRITER -- requirements
Module: array_writer

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 2, meaning table holds 2**ADDR_BITS entries.
REQ-002 The block SHALL have parameter WIDTH, default 25, meaning signed fixed-point word width of every real-valued port.
REQ-003 The block SHALL have parameter EXPONENT, default -16, meaning real value = signed word * 2**EXPONENT.
REQ-004 Ports SHALL be: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle request to begin a table load.
REQ-007 in_data  input  WIDTH  signed sample to be written.
REQ-008 in_valid  input  1  in_data valid this cycle.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 loaded  output  1  table fully written since last start.
REQ-011 busy  output  1  load in progress.
REQ-012 rd_addr  input  ADDR_BITS  read address.
REQ-013 rd_data  output  WIDTH  signed table word at registered rd_addr.

Function
REQ-014 FSM SHALL have states IDLE, LOAD, DONE; reset state IDLE.
REQ-015 IDLE: start=1 -> LOAD, wr_ptr cleared to 0, loaded cleared to 0.
REQ-016 LOAD: in_ready=1 and busy=1; outside LOAD both SHALL be 0.
REQ-017 Transfer SHALL occur exactly on cycles with in_valid=1 and in_ready=1; in_data written to entry wr_ptr on that edge, wr_ptr incremented by 1.
REQ-018 in_valid=0 in LOAD SHALL hold state, wr_ptr and table unchanged (stalls of any length allowed).
REQ-019 Transfer at wr_ptr = 2**ADDR_BITS-1 SHALL move FSM to DONE, wr_ptr wraps to 0, loaded=1 from the next cycle.
REQ-020 DONE: loaded held at 1; start=1 -> LOAD per REQ-015 (reload overwrites entries in order; unwritten entries keep old values).
REQ-021 start asserted while in LOAD SHALL be ignored; load continues unaffected.
REQ-022 Samples SHALL be stored bit-exact; no rounding, saturation or sign change.
REQ-023 rd_data SHALL equal table[rd_addr] sampled at the previous edge (1-cycle latency), in every state.
REQ-024 Read and write of the same entry on the same edge SHALL return the pre-write (old) value; new value visible from the following read.
REQ-025 Exactly 2**ADDR_BITS transfers SHALL complete a load; in_ready SHALL be 0 on the cycle after the final transfer.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force: state IDLE, wr_ptr 0, every table entry 0, rd_data 0, in_ready 0, busy 0, loaded 0.
REQ-027 rst asserted mid-load SHALL discard partially written contents (all entries 0); a new start is required after rst deasserts.
REQ-028 First clk edge after rst deasserts SHALL be a normal functional edge.

Verification (ADDR_BITS=2, WIDTH=25, EXPONENT=-16)
REQ-029 Reset, then sweep rd_addr 0..3 -> rd_data 0 every cycle, in_ready=0, loaded=0.
REQ-030 start, then in_valid=1 for 4 cycles with 10.0, -2.5, 0.0, 1.25 (655360, -163840, 0, 81920) -> busy 4 cycles, loaded=1 next cycle, reads of addr 0..3 return those words one cycle after each rd_addr.
REQ-031 Same load with in_valid low for 3 cycles between samples 2 and 3 -> identical final table, busy 7 cycles, no extra write.
REQ-032 During load, rd_addr=1 held on the edge writing entry 1 with 655360 (old value 0) -> rd_data 0 that cycle, 655360 on the next.
REQ-033 start pulsed again after 2 of 4 transfers -> ignored, load finishes after 2 more transfers, contents in transfer order.
REQ-034 Assert rst asynchronously after 3 transfers, between clk edges -> outputs 0 and state IDLE before next edge; all reads return 0; in_valid ignored until new start.
